trng_arbiter: RTL and testbench
===============================

Name: trng_arbiter

Overview:
- Shares the single 32-bit TRNG instance between NUM_REQ crypto clients (key generation, nonce and IV units).
- Sequences the TRNG's level handshake: raises trng_request, waits for ready, captures the word, then drops the request so the TRNG re-arms.
- Applies a lightweight online health check and returns each word to exactly one requester.
- Sits between the TRNG and the client request bus.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
TIMEOUT_CYCLES, 255, max cycles in WAIT_READY before a timeout abort
MAX_RETRY, 3, consecutive health rejections before the request fails

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
req  in  NUM_REQ  per-client request level; held until that client's rnd_valid or rnd_err
rnd_valid  out  NUM_REQ  one-cycle pulse to the served client; word on rnd_data
rnd_err  out  NUM_REQ  one-cycle pulse to the served client on timeout or retry exhaustion
rnd_data  out  32  delivered word; zero whenever rnd_valid is all-zero
trng_request  out  1  request level to the TRNG
trng_random_number  in  32  TRNG output word
trng_ready  in  1  TRNG ready level
busy  out  1  high in any state other than IDLE
health_fail  out  1  sticky flag, set on any retry exhaustion, cleared only by reset

Behaviour:
- Clocking and reset: one clock domain, clk. Reset is asynchronous, active-low (rst_n). All outputs are registered.
- Reset values: state=IDLE, all outputs 0, rr_ptr=NUM_REQ-1, last_word=0, retry_cnt=0, timer=0.
- States: IDLE, WAIT_READY, DELIVER, DRAIN.
- IDLE:
  - If any req bit is set, choose the owner round-robin, searching from rr_ptr+1 with wrap.
  - Register owner, clear timer and retry_cnt, go to WAIT_READY.
  - If no req bit is set, stay in IDLE.
- WAIT_READY:
  - trng_request=1; timer increments each cycle.
  - If trng_ready=1: capture trng_random_number.
    - Word is 0 or equals last_word: reject. retry_cnt++ and go to DRAIN with retry pending. If retry_cnt is already MAX_RETRY-1, instead set health_fail, schedule rnd_err[owner], go to DRAIN with no retry.
    - Otherwise: accept. Store the word in last_word and go to DELIVER.
  - Else if req[owner]=0 (client abort): go to DRAIN. No valid, no err.
  - Else if timer==TIMEOUT_CYCLES: schedule rnd_err[owner], go to DRAIN.
- DELIVER:
  - trng_request=0.
  - rnd_valid[owner]=1 and rnd_data=captured word for exactly this one cycle.
  - rr_ptr=owner; go to DRAIN.
- DRAIN:
  - trng_request=0; stay in DRAIN while trng_ready=1.
  - When trng_ready=0: a pending retry returns to WAIT_READY (same owner, timer cleared); otherwise go to IDLE.
  - A scheduled rnd_err[owner] pulses for one cycle on DRAIN entry, and rr_ptr=owner.
  - A client abort also sets rr_ptr=owner.
- Latency, nominal TRNG (32 collection cycles):
  - req high in cycle 0, sampled at edge 1.
  - trng_request high from cycle 1; trng_ready high in cycle 33.
  - rnd_valid high in cycle 34.
  - DRAIN occupies cycle 35; IDLE in cycle 36. Next arbitration takes effect at edge 37.
- Simultaneous events:
  - trng_ready=1 takes priority over abort and timeout in the same cycle.
  - On an accept with req[owner] already low, the word is still discarded. The client sees no valid, rnd_data stays 0, and last_word is updated.
- A req change from a non-owner never affects the current transaction.
- At most one rnd_valid or rnd_err bit is ever high, and never both.

Decomposition:
- Package trng_ctrl_pkg holds:
  - the state enum (IDLE, WAIT_READY, DELIVER, DRAIN);
  - WORD_W=32;
  - default TIMEOUT_CYCLES and MAX_RETRY constants.
- Sub-module rr_arbiter(NUM_REQ) is natural for the owner search:
  - inputs req and rr_ptr;
  - outputs a one-hot grant, an encoded index and any_req;
  - purely combinational.

Test Plan:
- Single client: req[0]=1 at cycle 0 with a TRNG model returning 0xA5A5_1234 -> trng_request in cycle 1, rnd_valid=0001 with rnd_data=0xA5A5_1234 in cycle 34, IDLE in cycle 36, rnd_data=0 otherwise.
- Fairness: req=1111 held continuously -> rnd_valid order 0001, 0010, 0100, 1000, 0001, with no client served twice before all others are served once.
- Health: TRNG returns 0x0, then the last accepted word, then 0x1111_2222 -> two DRAIN→WAIT_READY retries for the same owner, then rnd_valid with 0x1111_2222 and health_fail=0.
- Exhaustion: TRNG returns 0x0 three times (MAX_RETRY=3) -> rnd_err[owner] pulse, health_fail=1 and sticky, no rnd_valid, next requester served normally.
- Timeout/abort: TRNG ready tied low -> rnd_err at timer=255. Separately, owner drops req at cycle 10 -> trng_request drops in cycle 11, no pulses, next client granted.
- Reset mid-op: assert rst_n=0 in WAIT_READY at cycle 20 -> all outputs 0 immediately, state IDLE, rr_ptr=NUM_REQ-1, health_fail cleared.

Source files
------------

// File: rtl/trng_ctrl_pkg.sv
// Shared types and constants for the TRNG arbiter.
package trng_ctrl_pkg;

    localparam int WORD_W             = 32;
    localparam int DEF_TIMEOUT_CYCLES = 255;
    localparam int DEF_MAX_RETRY      = 3;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_READY = 2'd1,
        DELIVER    = 2'd2,
        DRAIN      = 2'd3
    } state_t;

    // Online health test: a stuck-at-zero word or an exact repeat of the
    // previously accepted word is rejected.
    function automatic logic word_healthy(input logic [WORD_W-1:0] word,
                                          input logic [WORD_W-1:0] last);
        return (word != '0) && (word != last);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin search: first set req bit after rr_ptr, with wrap.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int PW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PW-1:0]      rr_ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [PW-1:0]      grant_idx,
    output logic               any_req
);

    // Walk the requesters starting one past the last owner; first hit wins.
    always_comb begin
        logic [PW:0]   sum;
        logic [PW-1:0] idx;
        logic          found;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        sum       = '0;
        idx       = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            // rr_ptr + i never exceeds 2*NUM_REQ-1, so one subtraction wraps it.
            sum = {1'b0, rr_ptr} + (PW+1)'(i);
            if (sum >= (PW+1)'(NUM_REQ))
                sum = sum - (PW+1)'(NUM_REQ);
            idx = sum[PW-1:0];
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/trng_arbiter.sv
// Shares one 32-bit TRNG between NUM_REQ clients: arbitrates, runs the TRNG
// level handshake, health-checks each word and returns it to one client.
module trng_arbiter
    import trng_ctrl_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int MAX_RETRY      = DEF_MAX_RETRY
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_REQ-1:0]  req,
    output logic [NUM_REQ-1:0]  rnd_valid,
    output logic [NUM_REQ-1:0]  rnd_err,
    output logic [WORD_W-1:0]   rnd_data,
    output logic                trng_request,
    input  logic [WORD_W-1:0]   trng_random_number,
    input  logic                trng_ready,
    output logic                busy,
    output logic                health_fail
);

    localparam int PW = $clog2(NUM_REQ);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int RW = (MAX_RETRY > 1) ? $clog2(MAX_RETRY) : 1;

    state_t               state;
    logic [PW-1:0]        rr_ptr;
    logic [PW-1:0]        owner;
    logic [NUM_REQ-1:0]   owner_oh;
    logic [WORD_W-1:0]    last_word;
    logic [RW-1:0]        retry_cnt;
    logic [TW-1:0]        timer;
    logic                 retry_pend;

    logic [NUM_REQ-1:0]   grant;
    logic [PW-1:0]        grant_idx;
    logic                 any_req;
    logic                 owner_req;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PW      (PW)
    ) u_rr (
        .req       (req),
        .rr_ptr    (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any_req   (any_req)
    );

    // Only the owner's request line matters once a transaction is running.
    assign owner_req = |(req & owner_oh);

    // Control FSM; all client and TRNG outputs are registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            rr_ptr       <= PW'(NUM_REQ - 1);
            owner        <= '0;
            owner_oh     <= '0;
            last_word    <= '0;
            retry_cnt    <= '0;
            timer        <= '0;
            retry_pend   <= 1'b0;
            rnd_valid    <= '0;
            rnd_err      <= '0;
            rnd_data     <= '0;
            trng_request <= 1'b0;
            busy         <= 1'b0;
            health_fail  <= 1'b0;
        end else begin
            // Pulses last one cycle; data is zero unless a valid is driven.
            rnd_valid <= '0;
            rnd_err   <= '0;
            rnd_data  <= '0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        owner        <= grant_idx;
                        owner_oh     <= grant;
                        timer        <= '0;
                        retry_cnt    <= '0;
                        retry_pend   <= 1'b0;
                        trng_request <= 1'b1;
                        busy         <= 1'b1;
                        state        <= WAIT_READY;
                    end
                end

                WAIT_READY: begin
                    // A ready word wins over abort and timeout in the same cycle.
                    if (trng_ready) begin
                        trng_request <= 1'b0;
                        if (!word_healthy(trng_random_number, last_word)) begin
                            if (retry_cnt == RW'(MAX_RETRY - 1)) begin
                                health_fail <= 1'b1;
                                rnd_err     <= owner_oh;
                                rr_ptr      <= owner;
                                retry_pend  <= 1'b0;
                            end else begin
                                retry_cnt  <= retry_cnt + RW'(1);
                                retry_pend <= 1'b1;
                            end
                            state <= DRAIN;
                        end else begin
                            // Accepted words update history even if the owner left.
                            last_word <= trng_random_number;
                            if (owner_req) begin
                                rnd_valid <= owner_oh;
                                rnd_data  <= trng_random_number;
                            end
                            state <= DELIVER;
                        end
                    end else if (!owner_req) begin
                        trng_request <= 1'b0;
                        retry_pend   <= 1'b0;
                        rr_ptr       <= owner;
                        state        <= DRAIN;
                    end else if (timer == TW'(TIMEOUT_CYCLES)) begin
                        trng_request <= 1'b0;
                        retry_pend   <= 1'b0;
                        rnd_err      <= owner_oh;
                        rr_ptr       <= owner;
                        state        <= DRAIN;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end

                DELIVER: begin
                    rr_ptr     <= owner;
                    retry_pend <= 1'b0;
                    state      <= DRAIN;
                end

                DRAIN: begin
                    // Hold off until the TRNG has dropped ready and re-armed.
                    if (!trng_ready) begin
                        if (retry_pend) begin
                            retry_pend   <= 1'b0;
                            timer        <= '0;
                            trng_request <= 1'b1;
                            state        <= WAIT_READY;
                        end else begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end
                end

                default: begin
                    trng_request <= 1'b0;
                    busy         <= 1'b0;
                    state        <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_trng_arbiter.sv
// Bench for trng_arbiter: directed table, hand sequences, randomized traffic
// against a transaction-level model.
module tb_trng_arbiter;
    import trng_ctrl_pkg::*;

    localparam int N = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [N-1:0]      req = '0;
    logic [N-1:0]      rnd_valid, rnd_err;
    logic [31:0]       rnd_data;
    logic              trng_request;
    logic [31:0]       trng_random_number = '0;
    logic              trng_ready = 1'b0;
    logic              busy, health_fail;

    int checks = 0;
    int errors = 0;

    trng_arbiter #(.NUM_REQ(N)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .req                (req),
        .rnd_valid          (rnd_valid),
        .rnd_err            (rnd_err),
        .rnd_data           (rnd_data),
        .trng_request       (trng_request),
        .trng_random_number (trng_random_number),
        .trng_ready         (trng_ready),
        .busy               (busy),
        .health_fail        (health_fail)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    // ---------------- TRNG behavioural model ----------------
    int          ready_at = 32;    // ready rises after this many request-high cycles
    bit          tie_low = 1'b0;
    bit          rand_mode = 1'b0;
    logic [31:0] wq[$];            // directed word queue
    logic [31:0] issued[$];        // words handed out in the current transaction
    logic [31:0] prev_issued = '0;
    int          rcnt = 0;

    always @(negedge clk) begin
        if (!trng_request) begin
            trng_ready = 1'b0;
            rcnt = 0;
            if (rand_mode) ready_at = $urandom_range(0, 10);
        end else if (!trng_ready && !tie_low) begin
            rcnt++;
            if (rcnt > ready_at) begin
                trng_ready = 1'b1;
                if (wq.size() > 0) trng_random_number = wq.pop_front();
                else begin
                    case ($urandom_range(0, 3))
                        0: trng_random_number = '0;
                        1: trng_random_number = prev_issued;
                        default: trng_random_number = $urandom() | 32'h100;
                    endcase
                end
                prev_issued = trng_random_number;
                issued.push_back(trng_random_number);
            end
        end
    end

    // Always-on output invariants.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("mon_onehot", 32'($onehot0(rnd_valid | rnd_err)), 32'd1);
            chk("mon_v_and_e", 32'(rnd_valid & rnd_err), 32'd0);
            if (rnd_valid == '0) chk("mon_data_zero", rnd_data, 32'd0);
        end
    end

    // ---------------- helpers ----------------
    task automatic wait_event(input int limit, output bit found, output int rises, output int hi);
        bit prev;
        int t;
        found = 1'b0; rises = 0; hi = 0; t = 0; prev = trng_request;
        while (!found && t < limit) begin
            @(negedge clk);
            t++;
            if (trng_request && !prev) rises++;
            if (trng_request) hi++;
            prev = trng_request;
            if ((rnd_valid | rnd_err) != '0) found = 1'b1;
        end
        chk("event_wait", 32'(found), 32'd1);
    endtask

    task automatic wait_idle(input int limit);
        int t;
        t = 0;
        while (busy && t < limit) begin
            @(negedge clk);
            t++;
        end
        chk("idle_wait", 32'(busy), 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    typedef struct {
        logic [N-1:0] req;
        logic [31:0]  word;
        logic [N-1:0] exp_v;
        logic [31:0]  exp_d;
    } vec_t;
    vec_t tbl[6];

    // random-phase model state
    int           m_ptr, m_owner, rej, used, j;
    logic [31:0]  m_last, exp_word;
    logic [N-1:0] exp_oh, ev, dropped;
    bit           h_exp, outst, busy_q, exp_ok, exp_err;

    initial begin
        bit f;
        int r, h;

        // Reset state.
        repeat (2) @(negedge clk);
        chk("rst_valid", 32'(rnd_valid), 0);
        chk("rst_err", 32'(rnd_err), 0);
        chk("rst_data", rnd_data, 0);
        chk("rst_trng_req", 32'(trng_request), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_health", 32'(health_fail), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Nominal latency, single client: req in cycle 0.
        ready_at = 32;
        wq.push_back(32'hA5A5_1234);
        req = 4'b0001;
        for (int k = 1; k <= 37; k++) begin
            @(negedge clk);
            chk($sformatf("lat_treq_c%0d", k), 32'(trng_request), 32'(k <= 33));
            chk($sformatf("lat_valid_c%0d", k), 32'(rnd_valid), (k == 34) ? 32'd1 : 32'd0);
            chk($sformatf("lat_data_c%0d", k), rnd_data, (k == 34) ? 32'hA5A5_1234 : 32'd0);
            chk($sformatf("lat_busy_c%0d", k), 32'(busy), 32'(k <= 35));
            if (k == 34) req = '0;
        end

        // Table of single accepted transactions (round-robin continues from client 0).
        tbl[0] = '{4'b0011, 32'h0000_0001, 4'b0010, 32'h0000_0001};
        tbl[1] = '{4'b1001, 32'hDEAD_BEEF, 4'b1000, 32'hDEAD_BEEF};
        tbl[2] = '{4'b0110, 32'h0000_1234, 4'b0010, 32'h0000_1234};
        tbl[3] = '{4'b0101, 32'hFFFF_FFFF, 4'b0100, 32'hFFFF_FFFF};
        tbl[4] = '{4'b1111, 32'h0BAD_F00D, 4'b1000, 32'h0BAD_F00D};
        tbl[5] = '{4'b0001, 32'h0000_0002, 4'b0001, 32'h0000_0002};
        ready_at = 3;
        for (int i = 0; i < 6; i++) begin
            wq.push_back(tbl[i].word);
            req = tbl[i].req;
            wait_event(100, f, r, h);
            chk($sformatf("tbl%0d_valid", i), 32'(rnd_valid), 32'(tbl[i].exp_v));
            chk($sformatf("tbl%0d_data", i), rnd_data, tbl[i].exp_d);
            chk($sformatf("tbl%0d_err", i), 32'(rnd_err), 0);
            req = '0;
            wait_idle(50);
        end

        // Fairness with all four requesting continuously.
        do_reset();
        ready_at = 2;
        for (int i = 0; i < 5; i++) wq.push_back(32'h100 + 32'(i));
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            wait_event(100, f, r, h);
            chk($sformatf("fair%0d_valid", i), 32'(rnd_valid), 32'(1) << (i % N));
            chk($sformatf("fair%0d_data", i), rnd_data, 32'h100 + 32'(i));
        end
        req = '0;
        wait_idle(50);

        // Health rejects: zero, then repeat of last accepted, then good word.
        wq.push_back(32'h0); wq.push_back(32'h104); wq.push_back(32'h1111_2222);
        req = 4'b0100;
        wait_event(200, f, r, h);
        chk("health_valid", 32'(rnd_valid), 32'b0100);
        chk("health_data", rnd_data, 32'h1111_2222);
        chk("health_rises", 32'(r), 3);
        chk("health_flag", 32'(health_fail), 0);
        req = '0;
        wait_idle(50);

        // Retry exhaustion, then next requester served normally.
        wq.push_back(32'h0); wq.push_back(32'h0); wq.push_back(32'h0);
        req = 4'b1000;
        wait_event(200, f, r, h);
        chk("exh_err", 32'(rnd_err), 32'b1000);
        chk("exh_valid", 32'(rnd_valid), 0);
        chk("exh_rises", 32'(r), 3);
        chk("exh_flag", 32'(health_fail), 1);
        req = '0;
        wait_idle(50);
        wq.push_back(32'h5555_0001);
        req = 4'b0001;
        wait_event(100, f, r, h);
        chk("exh_next_valid", 32'(rnd_valid), 32'b0001);
        chk("exh_next_data", rnd_data, 32'h5555_0001);
        chk("exh_sticky", 32'(health_fail), 1);
        req = '0;
        wait_idle(50);

        // Timeout with ready tied low: request high for 256 cycles, then err.
        tie_low = 1'b1;
        req = 4'b0010;
        wait_event(400, f, r, h);
        chk("tmo_err", 32'(rnd_err), 32'b0010);
        chk("tmo_valid", 32'(rnd_valid), 0);
        chk("tmo_req_cycles", 32'(h), 256);
        req = '0;
        tie_low = 1'b0;
        wait_idle(50);

        // Client abort at cycle 10; client 0 is waiting and gets the next grant.
        ready_at = 50;
        wq.push_back(32'h7777_0000);
        req = 4'b0101;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            chk($sformatf("abort_treq_c%0d", k), 32'(trng_request), 32'(k <= 10));
            chk($sformatf("abort_pulse_c%0d", k), 32'(rnd_valid | rnd_err), 0);
            if (k == 10) req = 4'b0001;
        end
        wait_event(200, f, r, h);
        chk("abort_next_valid", 32'(rnd_valid), 32'b0001);
        chk("abort_next_data", rnd_data, 32'h7777_0000);
        req = '0;
        wait_idle(50);

        // Reset in the middle of WAIT_READY.
        ready_at = 200;
        req = 4'b0010;
        repeat (20) @(negedge clk);
        chk("mid_treq", 32'(trng_request), 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_treq", 32'(trng_request), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_health", 32'(health_fail), 0);
        chk("mid_rst_pulses", 32'(rnd_valid | rnd_err), 0);
        chk("mid_rst_data", rnd_data, 0);
        req = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ready_at = 5;
        wq.push_back(32'h3333_4444);
        req = 4'b1111;
        wait_event(100, f, r, h);
        chk("mid_first_valid", 32'(rnd_valid), 32'b0001);
        chk("mid_first_data", rnd_data, 32'h3333_4444);
        req = '0;
        wait_idle(50);

        // Randomized traffic against a transaction-level model.
        do_reset();
        rand_mode = 1'b1;
        issued.delete();
        m_ptr = N - 1; m_last = '0; h_exp = 1'b0; outst = 1'b0; busy_q = 1'b0;
        m_owner = -1; exp_oh = '0;
        for (int c = 0; c < 6000; c++) begin
            @(negedge clk);
            dropped = '0;
            ev = rnd_valid | rnd_err;
            if (!busy_q && busy) begin
                // The grant used the req value held over the last edge.
                chk("rnd_arb_req", 32'(req != '0), 1);
                m_owner = -1;
                for (int i = 1; i <= N; i++) begin
                    j = (m_ptr + i) % N;
                    if (req[j] && m_owner < 0) m_owner = j;
                end
                exp_oh = (m_owner >= 0) ? N'(1 << m_owner) : '0;
                outst = 1'b1;
            end
            busy_q = busy;
            if (ev != '0) begin
                chk("rnd_ev_owner", 32'(ev), outst ? 32'(exp_oh) : 32'd0);
                exp_ok = 1'b0; exp_err = 1'b0; rej = 0; used = 0; exp_word = '0;
                foreach (issued[i]) begin
                    if (!exp_ok && !exp_err) begin
                        used++;
                        if (issued[i] == 0 || issued[i] == m_last) begin
                            rej++;
                            if (rej == DEF_MAX_RETRY) exp_err = 1'b1;
                        end else begin
                            exp_ok = 1'b1;
                            exp_word = issued[i];
                        end
                    end
                end
                chk("rnd_words_used", 32'(used), 32'(issued.size()));
                chk("rnd_valid", 32'(rnd_valid), exp_ok ? 32'(exp_oh) : 32'd0);
                chk("rnd_err", 32'(rnd_err), exp_err ? 32'(exp_oh) : 32'd0);
                chk("rnd_data", rnd_data, exp_ok ? exp_word : 32'd0);
                if (exp_ok) m_last = exp_word;
                if (exp_err) h_exp = 1'b1;
                if (m_owner >= 0) m_ptr = m_owner;
                outst = 1'b0;
                issued.delete();
                dropped = ev;
                req = req & ~ev;
            end
            chk("rnd_health", 32'(health_fail), 32'(h_exp));
            if (c < 5000) begin
                for (int i = 0; i < N; i++)
                    if (!req[i] && !dropped[i] && $urandom_range(0, 5) == 0) req[i] = 1'b1;
            end
        end
        chk("rnd_drained_req", 32'(req), 0);
        chk("rnd_drained_busy", 32'(busy), 0);
        rand_mode = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
